// File: rtl/sine_dds_pkg.sv
// Shared types and helpers for the multiphase DDS sine source: FSM states,
// quadrant fold decode and the per-channel phase offset.
package sine_dds_pkg;

  typedef enum logic [2:0] {IDLE, ADDR, READ, WRITE, COMMIT} dds_state_e;

  typedef longint unsigned u64_t;

  typedef struct packed {
    logic mirror;  // odd quadrants walk the quarter table backwards
    logic neg;     // lower half-wave
  } quad_t;

  function automatic quad_t quad_decode(input logic [1:0] q);
    quad_t r;
    r.mirror = q[0];
    r.neg    = q[1];
    return r;
  endfunction

  // floor(k * 2^w / n): channel k lags channel 0 by k/n of a turn
  function automatic u64_t phase_offset(input int k, input int n, input int w);
    return (u64_t'(k) << w) / u64_t'(n);
  endfunction

endpackage

// File: rtl/sine_quarter_rom.sv
// Quarter-wave sine magnitude ROM, synchronous read with one cycle latency.
// Contents are computed at elaboration: round(FS*sin(pi/2*(n+0.5)/2^LUT_AW)).
module sine_quarter_rom #(
  parameter int LUT_AW = 8,
  parameter int DATA_W = 12
) (
  input  logic              clk,
  input  logic [LUT_AW-1:0] addr,
  output logic [DATA_W-2:0] data
);

  localparam longint PI_Q30 = 64'sd3373259426;  // pi * 2^30
  localparam longint FS     = longint'(2**(DATA_W-1) - 1);

  // Fixed-point Q30 Taylor series; error is far below one output LSB.
  function automatic logic [DATA_W-2:0] mag_at(input int n);
    longint x, x2, term, sum;
    x    = (PI_Q30 * longint'(2*n + 1)) >>> (LUT_AW + 2);
    x2   = (x * x) >>> 30;
    term = x;
    sum  = x;
    for (int k = 1; k < 8; k++) begin
      term = -((term * x2) >>> 30) / longint'((2*k) * (2*k + 1));
      sum  = sum + term;
    end
    return (DATA_W-1)'((sum * FS + (longint'(1) <<< 29)) >>> 30);
  endfunction

  logic [DATA_W-2:0] rom [2**LUT_AW];
  logic [DATA_W-2:0] data_q;

  for (genvar n = 0; n < 2**LUT_AW; n++) begin : g_rom
    assign rom[n] = mag_at(n);
  end

  always_ff @(posedge clk) data_q <= rom[addr];

  assign data = data_q;

endmodule

// File: rtl/sine_dds_multiphase.sv
// NUM_CH-phase DDS sine source sharing one quarter-wave ROM, 3 cycles/channel.
// Define SINE_DDS_AMP_SCALE_EN to add an 8-bit amplitude scale input (amp).
module sine_dds_multiphase
  import sine_dds_pkg::*;
#(
  parameter int DATA_W  = 12,
  parameter int PHASE_W = 24,
  parameter int LUT_AW  = 8,
  parameter int NUM_CH  = 3,
  parameter int CLK_DIV = 12
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic [PHASE_W-1:0]       freq_word,
`ifdef SINE_DDS_AMP_SCALE_EN
  input  logic [7:0]               amp,
`endif
  output logic [NUM_CH*DATA_W-1:0] out_ch,
  output logic                     out_valid,
  output logic                     overrun
);

  localparam int CH_W  = (NUM_CH  > 1) ? $clog2(NUM_CH)  : 1;
  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  dds_state_e                     state_q, state_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic [PHASE_W-1:0]             acc_q, acc_d;
  logic [CH_W-1:0]                ch_q, ch_d;
  logic [LUT_AW-1:0]              addr_q, addr_d;
  logic                           neg_q, neg_d;
  logic [NUM_CH-1:0][DATA_W-1:0]  shadow_q, shadow_d, out_q, out_d;
  logic                           out_valid_q, out_valid_d, overrun_q, overrun_d;

  logic [NUM_CH-1:0][PHASE_W-1:0] offs;
  logic [LUT_AW+1:0]              ph_hi;
  quad_t                          qd;
  logic                           tick;
  logic [DATA_W-2:0]              mag;
  logic signed [DATA_W-1:0]       sample, scaled;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_offs
    assign offs[k] = PHASE_W'(phase_offset(k, NUM_CH, PHASE_W));
  end

  // Only the quadrant and table index of the channel phase matter.
  assign ph_hi = (LUT_AW+2)'((acc_q - offs[ch_q]) >> (PHASE_W - LUT_AW - 2));
  assign qd    = quad_decode(ph_hi[LUT_AW+1 -: 2]);
  assign tick  = en && (cnt_q == CNT_W'(CLK_DIV - 1));

  sine_quarter_rom #(.LUT_AW(LUT_AW), .DATA_W(DATA_W)) u_rom (
    .clk  (clk),
    .addr (addr_q),
    .data (mag)
  );

  assign sample = neg_q ? -$signed({1'b0, mag}) : $signed({1'b0, mag});

`ifdef SINE_DDS_AMP_SCALE_EN
  logic [7:0]               amp_q, amp_d;
  logic signed [DATA_W+8:0] prod;
  assign prod   = sample * $signed({1'b0, amp_q});
  assign scaled = DATA_W'(prod >>> 8);
`else
  assign scaled = sample;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    ch_d        = ch_q;
    addr_d      = addr_q;
    neg_d       = neg_q;
    shadow_d    = shadow_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    overrun_d   = overrun_q;
`ifdef SINE_DDS_AMP_SCALE_EN
    amp_d       = amp_q;
`endif
    if (en) cnt_d = tick ? '0 : cnt_q + 1'b1;
    if (tick) begin
      acc_d = acc_q + freq_word;
      if (state_q == IDLE) begin
        ch_d    = '0;
        state_d = ADDR;
`ifdef SINE_DDS_AMP_SCALE_EN
        amp_d   = amp;
`endif
      end else begin
        overrun_d = 1'b1;
      end
    end
    case (state_q)
      ADDR: begin
        addr_d  = qd.mirror ? ~ph_hi[LUT_AW-1:0] : ph_hi[LUT_AW-1:0];
        neg_d   = qd.neg;
        state_d = READ;
      end
      READ: state_d = WRITE;
      WRITE: begin
        shadow_d[ch_q] = scaled;
        if (ch_q == CH_W'(NUM_CH - 1)) begin
          state_d = COMMIT;
        end else begin
          ch_d    = ch_q + 1'b1;
          state_d = ADDR;
        end
      end
      COMMIT: begin
        out_d       = shadow_q;
        out_valid_d = 1'b1;
        state_d     = IDLE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      ch_q        <= '0;
      addr_q      <= '0;
      neg_q       <= 1'b0;
      shadow_q    <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      ch_q        <= ch_d;
      addr_q      <= addr_d;
      neg_q       <= neg_d;
      shadow_q    <= shadow_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
    end
  end

`ifdef SINE_DDS_AMP_SCALE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) amp_q <= '0;
    else        amp_q <= amp_d;
  end
`endif

  assign out_ch    = out_q;
  assign out_valid = out_valid_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_sine_dds_multiphase.sv
// Scoreboard bench: a behavioural model predicts each commit from tick rules and
// real-valued sine; a negedge monitor pops and compares whenever out_valid is due.
module tb_sine_dds_multiphase;

  localparam int N = 3, PW = 24, DW = 12, LAW = 8, CD = 12, LAT = 3*N + 1;

  logic clk = 1'b0;
  logic rst_n, rst4_n, en;
  logic [PW-1:0] fw;
`ifdef SINE_DDS_AMP_SCALE_EN
  logic [7:0] amp;
`endif
  logic [N*DW-1:0] out_ch, out4;
  logic out_valid, overrun, v4, ov4;

  always #5 clk = ~clk;

  sine_dds_multiphase dut (
    .clk(clk), .rst_n(rst_n), .en(en), .freq_word(fw),
`ifdef SINE_DDS_AMP_SCALE_EN
    .amp(amp),
`endif
    .out_ch(out_ch), .out_valid(out_valid), .overrun(overrun)
  );

  sine_dds_multiphase #(.CLK_DIV(4)) dut4 (
    .clk(clk), .rst_n(rst4_n), .en(1'b1), .freq_word(24'h400000),
`ifdef SINE_DDS_AMP_SCALE_EN
    .amp(amp),
`endif
    .out_ch(out4), .out_valid(v4), .overrun(ov4)
  );

  typedef struct packed {
    logic [31:0]               due;
    logic [N-1:0][DW-1:0]      s;
  } exp_t;

  int checks = 0, errors = 0;
  int mag [2**LAW];
  exp_t sb[$];
  exp_t ne, pe;
  int ecnt, en_cnt, start;
  logic [PW-1:0] acc;
  logic m_ovr, exp_v;
  logic [N-1:0][DW-1:0] hold;
  int cap0[$], cap1[$], cap2[$];
  int seq [4];
  int zero_ph;

  function automatic void chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d", nm, act, exp);
    end
  endfunction

  // Ideal sample for a channel phase: quarter-wave fold of a rounded sine table.
  function automatic int model_sample(input logic [PW-1:0] ph);
    int q, i, m, s;
    q = int'(ph[PW-1 -: 2]);
    i = int'(ph[PW-3 -: LAW]);
    m = mag[(q % 2 == 1) ? (2**LAW - 1 - i) : i];
    s = (q >= 2) ? -m : m;
`ifdef SINE_DDS_AMP_SCALE_EN
    s = (s * int'(amp)) >>> 8;
`endif
    return s;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      ecnt = 0; en_cnt = 0; start = -1000; acc = '0; m_ovr = 1'b0;
      sb.delete();
    end else begin
      ecnt++;
      if (en) begin
        en_cnt++;
        if (en_cnt % CD == 0) begin
          acc = acc + fw;
          if (ecnt <= start + LAT) m_ovr = 1'b1;
          else begin
            ne.due = 32'(ecnt + LAT);
            for (int k = 0; k < N; k++)
              ne.s[k] = DW'(model_sample(acc - PW'((longint'(k) << PW) / longint'(N))));
            sb.push_back(ne);
            start = ecnt;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      hold = '0;
      chk("rst_out_valid", longint'(out_valid), 0);
      chk("rst_overrun", longint'(overrun), 0);
      chk("rst_out_ch", longint'(out_ch), 0);
    end else begin
      exp_v = (sb.size() > 0) && (sb[0].due == 32'(ecnt));
      chk("out_valid", longint'(out_valid), longint'(exp_v));
      if (exp_v) begin
        pe = sb.pop_front();
        hold = pe.s;
      end
      if (out_valid) begin
        cap0.push_back(int'($signed(out_ch[0*DW +: DW])));
        cap1.push_back(int'($signed(out_ch[1*DW +: DW])));
        cap2.push_back(int'($signed(out_ch[2*DW +: DW])));
      end
      for (int k = 0; k < N; k++)
        chk("ch_sample", longint'($signed(out_ch[k*DW +: DW])), longint'($signed(hold[k])));
      chk("overrun", longint'(overrun), longint'(m_ovr));
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic clr_cap();
    cap0.delete(); cap1.delete(); cap2.delete();
  endtask

  initial begin
    int pulses, first4;
    logic ovmin;
    for (int n = 0; n < 2**LAW; n++)
      mag[n] = $rtoi(real'(2**(DW-1) - 1) * $sin(3.14159265358979 / 2.0 * (real'(n) + 0.5) / real'(2**LAW)) + 0.5);
`ifdef SINE_DDS_AMP_SCALE_EN
    seq = '{1023, -3, -1024, 3}; zero_ph = 3; amp = 8'd128;
`else
    seq = '{2047, -6, -2047, 6}; zero_ph = 6;
`endif
    rst_n = 1'b0; rst4_n = 1'b0; en = 1'b1; fw = 24'h400000;
    step(5);
    rst_n = 1'b1;
    clr_cap();
    step(60);
    chk("seq_count", cap0.size(), 4);
    if (cap0.size() == 4)
      for (int k = 0; k < 4; k++) chk("seq_ch0", cap0[k], seq[k]);

    // frozen phase (also aborts the computation started on the last tick)
    rst_n = 1'b0; step(2); fw = '0; rst_n = 1'b1; clr_cap();
    step(36);
    chk("frz_count", cap0.size(), 2);
    if (cap0.size() == 2) begin
      chk("frz_ch0_a", cap0[0], zero_ph);
      chk("frz_ch0_b", cap0[1], zero_ph);
`ifndef SINE_DDS_AMP_SCALE_EN
      chk("frz_ch1_vs_ch2", cap1[0], -cap2[0]);
`endif
    end

    // en dropped one cycle after a tick
    rst_n = 1'b0; step(2); fw = 24'h1A2B3C; rst_n = 1'b1; clr_cap();
    step(13); en = 1'b0;
    step(40);
    chk("endrop_commit", cap0.size(), 1);
    en = 1'b1;
    step(30);
    chk("endrop_resume", cap0.size(), 2);

`ifdef SINE_DDS_AMP_SCALE_EN
    rst_n = 1'b0; step(2); amp = 8'd0; fw = 24'h123456; rst_n = 1'b1; clr_cap();
    step(26);
    chk("amp0_count", cap0.size(), 1);
    if (cap0.size() == 1) begin
      chk("amp0_ch0", cap0[0], 0); chk("amp0_ch1", cap1[0], 0); chk("amp0_ch2", cap2[0], 0);
    end
`endif

    // randomized run with en gaps, frequency changes and occasional resets
    rst_n = 1'b0; step(2); rst_n = 1'b1;
    for (int c = 0; c < 700; c++) begin
      if ($urandom_range(0, 19) == 0) fw = PW'($urandom);
      en = ($urandom_range(0, 7) != 0);
`ifdef SINE_DDS_AMP_SCALE_EN
      if ($urandom_range(0, 24) == 0) amp = 8'($urandom_range(0, 255));
`endif
      if ($urandom_range(0, 299) == 0) begin
        rst_n = 1'b0; step(1); rst_n = 1'b1;
      end
      step(1);
    end
    en = 1'b1;
    step(15);

    // CLK_DIV below the minimum: overrun becomes sticky, commits continue
`ifdef SINE_DDS_AMP_SCALE_EN
    amp = 8'd128;
`endif
    rst4_n = 1'b1;
    step(6);
    chk("ovr_after_tick1", longint'(ov4), 0);
    step(3);
    chk("ovr_after_tick2", longint'(ov4), 1);
    pulses = 0; first4 = 0; ovmin = 1'b1;
    for (int c = 0; c < 40; c++) begin
      step(1);
      ovmin &= ov4;
      if (v4) begin
        if (pulses == 0) first4 = int'($signed(out4[DW-1:0]));
        pulses++;
      end
    end
    chk("ovr_commits", pulses, 3);
    chk("ovr_first_ch0", first4, seq[0]);
    chk("ovr_sticky", longint'(ovmin), 1);
    rst4_n = 1'b0;
    #1;
    chk("ovr_cleared", longint'(ov4), 0);
    chk("ovr_valid_cleared", longint'(v4), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
